// File: rtl/spi_rom_responder_pkg.sv
// Shared constants for the SPI flash-ROM responder: opcode, frame lengths
// and FSM state encodings.
package spi_rom_responder_pkg;

    localparam logic [7:0] SPI_CMD_READ = 8'h03;
    localparam int SPI_CMD_LEN  = 8;
    localparam int SPI_ADDR_LEN = 24;
    localparam int SPI_DATA_LEN = 8;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CMD    = 3'd1;
    localparam logic [2:0] ST_ADDR   = 3'd2;
    localparam logic [2:0] ST_DATA   = 3'd3;
    localparam logic [2:0] ST_IGNORE = 3'd4;

    // Bit-counter value reached on the last bit of a field of the given length.
    function automatic logic [4:0] cnt_last(input int len);
        return 5'(len - 1);
    endfunction

endpackage

// File: rtl/spi_rom_responder_edge_sync.sv
// Synchronizer for one SPI pin: SYNC_STAGES flops, then registered rise/fall
// pulses aligned with the synchronized level.
module spi_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    // sync_q[SYNC_STAGES-1] is the last synchronizer stage, sync_q[SYNC_STAGES] the previous sample.
    logic [SYNC_STAGES:0] sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-1:0], din};
            rise   <= sync_q[SYNC_STAGES-1] & ~sync_q[SYNC_STAGES];
            fall   <= ~sync_q[SYNC_STAGES-1] & sync_q[SYNC_STAGES];
        end
    end

    assign level = sync_q[SYNC_STAGES];

endmodule

// File: rtl/spi_rom_responder.sv
// SPI flash-ROM emulator: decodes READ (0x03) + 24-bit address, then streams
// bytes from a synchronous external memory MSB-first until CS drops.
module spi_rom_responder
    import spi_rom_responder_pkg::*;
#(
    parameter int ADDR_BITS   = 11,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 spi_cs,
    input  logic                 spi_sclk,
    input  logic                 spi_mosi,
    output logic                 spi_miso,
    output logic [ADDR_BITS-1:0] rom_addr,
    output logic                 rom_re,
    input  logic [7:0]           rom_data,
    output logic                 busy,
    output logic                 cmd_err
);

    logic cs_lvl, cs_rise, cs_fall;
    logic sclk_lvl, sclk_rise, sclk_fall;
    logic mosi_lvl, mosi_rise, mosi_fall;

    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_cs_sync (
        .clk(clk), .reset(reset), .din(spi_cs),
        .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
    );

    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
        .clk(clk), .reset(reset), .din(spi_sclk),
        .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_mosi_sync (
        .clk(clk), .reset(reset), .din(spi_mosi),
        .level(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall)
    );

    logic unused_sync;
    assign unused_sync = ^{cs_fall, sclk_lvl, mosi_rise, mosi_fall};

    logic [2:0]           state;
    logic [4:0]           bit_cnt;
    logic [7:0]           cmd_sr;
    logic [ADDR_BITS-1:0] addr_sr;
    logic [7:0]           out_sr;
    logic                 load_p1;
    logic [7:0]           cmd_next;
    logic [ADDR_BITS-1:0] addr_next;

    // Only the low ADDR_BITS of the 24-bit address survive the shift.
    assign cmd_next  = {cmd_sr[6:0], mosi_lvl};
    assign addr_next = {addr_sr[ADDR_BITS-2:0], mosi_lvl};
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            cmd_sr   <= '0;
            addr_sr  <= '0;
            out_sr   <= '0;
            load_p1  <= 1'b0;
            spi_miso <= 1'b0;
            rom_addr <= '0;
            rom_re   <= 1'b0;
            cmd_err  <= 1'b0;
        end else begin
            rom_re  <= 1'b0;
            cmd_err <= 1'b0;
            load_p1 <= rom_re;
            // CS low overrides any SCLK edge seen in the same cycle.
            if (state != ST_IDLE && !cs_lvl) begin
                state    <= ST_IDLE;
                bit_cnt  <= '0;
                cmd_sr   <= '0;
                addr_sr  <= '0;
                out_sr   <= '0;
                load_p1  <= 1'b0;
                spi_miso <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        spi_miso <= 1'b0;
                        bit_cnt  <= '0;
                        if (cs_rise) state <= ST_CMD;
                    end
                    ST_CMD: begin
                        if (sclk_rise) begin
                            cmd_sr <= cmd_next;
                            if (bit_cnt == cnt_last(SPI_CMD_LEN)) begin
                                bit_cnt <= '0;
                                if (cmd_next == SPI_CMD_READ) begin
                                    state <= ST_ADDR;
                                end else begin
                                    cmd_err <= 1'b1;
                                    state   <= ST_IGNORE;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 5'd1;
                            end
                        end
                    end
                    ST_ADDR: begin
                        if (sclk_rise) begin
                            addr_sr <= addr_next;
                            if (bit_cnt == cnt_last(SPI_ADDR_LEN)) begin
                                bit_cnt  <= '0;
                                rom_addr <= addr_next;
                                rom_re   <= 1'b1;
                                state    <= ST_DATA;
                            end else begin
                                bit_cnt <= bit_cnt + 5'd1;
                            end
                        end
                    end
                    ST_DATA: begin
                        // Fetched byte lands well before the next SCLK fall.
                        if (load_p1) begin
                            out_sr <= rom_data;
                        end else if (sclk_fall) begin
                            spi_miso <= out_sr[7];
                            out_sr   <= {out_sr[6:0], 1'b0};
                            if (bit_cnt == cnt_last(SPI_DATA_LEN)) begin
                                bit_cnt  <= '0;
                                rom_addr <= rom_addr + 1'b1;
                                rom_re   <= 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt + 5'd1;
                            end
                        end
                    end
                    ST_IGNORE: begin
                        spi_miso <= 1'b0;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_rom_responder.sv
// Directed bench for spi_rom_responder: SPI mode-0 initiator, 2K x 8 sync ROM.
module tb_spi_rom_responder;

    localparam int AW   = 11;
    localparam int HALF = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          spi_cs;
    logic          spi_sclk;
    logic          spi_mosi;
    logic          spi_miso;
    logic [AW-1:0] rom_addr;
    logic          rom_re;
    logic [7:0]    rom_data;
    logic          busy;
    logic          cmd_err;

    int n_vec = 0;
    int n_err = 0;
    int re_cnt = 0;
    int err_cyc = 0;
    int miso_hi = 0;

    logic [7:0] mem [0:(1<<AW)-1];
    logic [7:0] rx_buf [0:15];

    always #5 clk = ~clk;

    spi_rom_responder #(.ADDR_BITS(AW), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset),
        .spi_cs(spi_cs), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
        .rom_addr(rom_addr), .rom_re(rom_re), .rom_data(rom_data),
        .busy(busy), .cmd_err(cmd_err)
    );

    function automatic logic [7:0] rom_val(input logic [AW-1:0] a);
        return a[7:0] ^ {a[10:8], 5'b0};
    endfunction

    always_ff @(posedge clk) begin
        if (rom_re) rom_data <= mem[rom_addr];
    end

    always @(negedge clk) begin
        if (rom_re) re_cnt++;
        if (cmd_err) err_cyc++;
        if (spi_miso) miso_hi++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic spi_bit(input logic b, output logic r);
        spi_mosi = b;
        repeat (HALF) @(negedge clk);
        r = spi_miso;
        spi_sclk = 1'b1;
        repeat (HALF) @(negedge clk);
        spi_sclk = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(tx[i], r);
            rx[i] = r;
        end
    endtask

    task automatic cs_on();
        spi_cs = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic cs_off();
        spi_cs   = 1'b0;
        spi_mosi = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic spi_read(input logic [7:0] cmd, input logic [23:0] addr, input int nbytes);
        logic [7:0] dummy;
        cs_on();
        spi_byte(cmd, dummy);
        spi_byte(addr[23:16], dummy);
        spi_byte(addr[15:8], dummy);
        spi_byte(addr[7:0], dummy);
        for (int k = 0; k < nbytes; k++) spi_byte(8'h00, rx_buf[k]);
        cs_off();
    endtask

    initial begin
        int re_base, err_base, hi_base;
        logic [7:0] rb;
        logic r;
        logic [AW-1:0] a;
        logic [23:0] burst_addr [0:1];

        for (int i = 0; i < (1 << AW); i++) mem[i] = rom_val(AW'(i));
        burst_addr[0] = 24'h5A0200;
        burst_addr[1] = 24'h0007F8;

        reset = 1'b1; spi_cs = 1'b0; spi_sclk = 1'b0; spi_mosi = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst miso", 32'(spi_miso), 32'h0);
        chk("rst rom_addr", 32'(rom_addr), 32'h0);
        chk("rst rom_re", 32'(rom_re), 32'h0);
        chk("rst busy", 32'(busy), 32'h0);
        chk("rst cmd_err", 32'(cmd_err), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // Basic read of 4 bytes at 0x10
        re_base = re_cnt; err_base = err_cyc;
        spi_read(8'h03, 24'h000010, 4);
        chk("t1 byte0", 32'(rx_buf[0]), 32'h10);
        chk("t1 byte1", 32'(rx_buf[1]), 32'h11);
        chk("t1 byte2", 32'(rx_buf[2]), 32'h12);
        chk("t1 byte3", 32'(rx_buf[3]), 32'h13);
        chk("t1 rom_re count", 32'(re_cnt - re_base), 32'd5);
        chk("t1 cmd_err", 32'(err_cyc - err_base), 32'd0);
        chk("t1 busy after cs", 32'(busy), 32'h0);

        // Wrap-around at top of the 2K space
        spi_read(8'h03, 24'h0007FE, 4);
        chk("t2 byte0", 32'(rx_buf[0]), 32'h1E);
        chk("t2 byte1", 32'(rx_buf[1]), 32'h1F);
        chk("t2 byte2", 32'(rx_buf[2]), 32'h00);
        chk("t2 byte3", 32'(rx_buf[3]), 32'h01);

        // Bad opcode 0x0B then 40 clocks
        re_base = re_cnt; err_base = err_cyc; hi_base = miso_hi;
        cs_on();
        spi_byte(8'h0B, rb);
        for (int i = 0; i < 40; i++) spi_bit(1'b1, r);
        chk("t3 busy in ignore", 32'(busy), 32'h1);
        cs_off();
        chk("t3 cmd_err cycles", 32'(err_cyc - err_base), 32'd1);
        chk("t3 rom_re count", 32'(re_cnt - re_base), 32'd0);
        chk("t3 miso high cycles", 32'(miso_hi - hi_base), 32'd0);
        chk("t3 busy after cs", 32'(busy), 32'h0);

        // Abort after 20 address bits, then clean read of 0x100
        re_base = re_cnt;
        cs_on();
        spi_byte(8'h03, rb);
        for (int i = 0; i < 20; i++) spi_bit(1'b1, r);
        cs_off();
        chk("t4 abort rom_re", 32'(re_cnt - re_base), 32'd0);
        chk("t4 abort busy", 32'(busy), 32'h0);
        spi_read(8'h03, 24'h000100, 2);
        chk("t4 byte0", 32'(rx_buf[0]), 32'h20);
        chk("t4 byte1", 32'(rx_buf[1]), 32'h21);

        // Reset in the middle of the second data byte (0x11 = 0001_0001: bit 4 is 1)
        cs_on();
        spi_byte(8'h03, rb);
        spi_byte(8'h00, rb);
        spi_byte(8'h00, rb);
        spi_byte(8'h10, rb);
        spi_byte(8'h00, rb);
        chk("t5 byte0", 32'(rb), 32'h10);
        for (int i = 0; i < 4; i++) spi_bit(1'b0, r);
        chk("t5 bit4 pre-reset", 32'(r), 32'h1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("t5 rst miso", 32'(spi_miso), 32'h0);
        chk("t5 rst busy", 32'(busy), 32'h0);
        chk("t5 rst rom_addr", 32'(rom_addr), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        cs_off();
        spi_read(8'h03, 24'h000012, 2);
        chk("t5 after byte0", 32'(rx_buf[0]), 32'h12);
        chk("t5 after byte1", 32'(rx_buf[1]), 32'h13);

        // Two 160-bit bursts at 10 clk per SCLK period
        for (int b = 0; b < 2; b++) begin
            spi_read(8'h03, burst_addr[b], 16);
            for (int k = 0; k < 16; k++) begin
                a = burst_addr[b][AW-1:0] + AW'(k);
                chk($sformatf("t6 burst%0d byte%0d", b, k), 32'(rx_buf[k]), 32'(rom_val(a)));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
